// File: rtl/tx_arbiter.sv
// tx_arbiter: shares one byte transmitter between an echo path (received bytes
// held in a one-entry overwrite register) and a local level-request port.
// Requests are served round-robin. Each transfer waits for the transmitter to
// go busy and then idle again, with a short timeout in case it never goes busy.
// Optional feature macro: ECHO_ERR_DROP_EN drops errored echo bytes and counts
// them in err_cnt. Without it, errored bytes are echoed and err_cnt reads 0.
module tx_arbiter (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  input  logic       rx_err,
  input  logic       loc_req,
  input  logic [7:0] loc_byte,
  output logic       loc_ack,
  output logic [7:0] tx_byte,
  output logic       tx_send,
  input  logic       tx_available,
  output logic       busy,
  output logic [7:0] ovr_cnt,
  output logic [7:0] err_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t      state_q;
  logic        txSend_q;
  logic        locAck_q;
  logic        busy_q;
  logic        lastLocal_q;
  logic [7:0]  txByte_q;
  logic [2:0]  toCnt_q;

  logic        echoPend_q;
  logic        echoPend_d;
  logic [7:0]  echoByte_q;
  logic [7:0]  echoByte_d;
  logic [7:0]  ovrCnt_q;
  logic [7:0]  ovrCnt_d;

  logic        grantEcho;
  logic        grantLoc;
  logic        rxLoad;

`ifdef ECHO_ERR_DROP_EN
  logic        rxDrop;
  logic [7:0]  errCnt_q;
  logic [7:0]  errCnt_d;

  assign rxLoad = rx_valid & ~rx_err;
  assign rxDrop = rx_valid & rx_err;

  // Errored echo bytes are discarded; tally them, saturating at 255
  always_comb begin
    errCnt_d = errCnt_q;
    if (rxDrop && errCnt_q != 8'hFF) begin
      errCnt_d = errCnt_q + 8'd1;
    end
  end

  // Error counter register
  always_ff @(posedge clock) begin
    if (reset) begin
      errCnt_q <= 8'h00;
    end else begin
      errCnt_q <= errCnt_d;
    end
  end

  assign err_cnt = errCnt_q;
`else
  logic        unusedRxErr;

  assign unusedRxErr = rx_err;
  assign rxLoad      = rx_valid;
  assign err_cnt     = 8'h00;
`endif

  // Grant only from IDLE with the transmitter free; on a tie, alternate
  always_comb begin
    grantEcho = 1'b0;
    grantLoc  = 1'b0;
    if (state_q == IDLE && tx_available) begin
      if (echoPend_q && loc_req) begin
        if (lastLocal_q) begin
          grantEcho = 1'b1;
        end else begin
          grantLoc = 1'b1;
        end
      end else if (echoPend_q) begin
        grantEcho = 1'b1;
      end else if (loc_req) begin
        grantLoc = 1'b1;
      end
    end
  end

  // Echo slot: a new byte always wins; overwriting an unsent byte is an overrun
  always_comb begin
    echoPend_d = echoPend_q;
    echoByte_d = echoByte_q;
    ovrCnt_d   = ovrCnt_q;
    if (rxLoad) begin
      echoByte_d = rx_byte;
      echoPend_d = 1'b1;
      if (echoPend_q && !grantEcho && ovrCnt_q != 8'hFF) begin
        ovrCnt_d = ovrCnt_q + 8'd1;
      end
    end else if (grantEcho) begin
      echoPend_d = 1'b0;
    end
  end

  // Echo slot and overrun counter registers
  always_ff @(posedge clock) begin
    if (reset) begin
      echoPend_q <= 1'b0;
      echoByte_q <= 8'h00;
      ovrCnt_q   <= 8'h00;
    end else begin
      echoPend_q <= echoPend_d;
      echoByte_q <= echoByte_d;
      ovrCnt_q   <= ovrCnt_d;
    end
  end

  // Transfer sequencer: grant, launch pulse, wait for busy, wait for idle
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      txSend_q    <= 1'b0;
      locAck_q    <= 1'b0;
      busy_q      <= 1'b0;
      txByte_q    <= 8'h00;
      toCnt_q     <= 3'd0;
      lastLocal_q <= 1'b1;
    end else begin
      txSend_q <= 1'b0;
      locAck_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grantEcho || grantLoc) begin
            state_q     <= LAUNCH;
            busy_q      <= 1'b1;
            txSend_q    <= 1'b1;
            locAck_q    <= grantLoc;
            txByte_q    <= grantLoc ? loc_byte : echoByte_q;
            lastLocal_q <= grantLoc;
          end
        end
        LAUNCH: begin
          state_q <= WAIT_BUSY;
          toCnt_q <= 3'd0;
        end
        WAIT_BUSY: begin
          if (!tx_available) begin
            state_q <= WAIT_DONE;
          end else if (toCnt_q == 3'd7) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            toCnt_q <= toCnt_q + 3'd1;
          end
        end
        WAIT_DONE: begin
          if (tx_available) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tx_send = txSend_q;
  assign loc_ack = locAck_q;
  assign busy    = busy_q;
  assign tx_byte = txByte_q;
  assign ovr_cnt = ovrCnt_q;

endmodule

// File: tb/tb_tx_arbiter.sv
// Testbench for tx_arbiter: directed scenarios followed by a randomized run
// checked against a transaction-level reference model.
// Honors ECHO_ERR_DROP_EN the same way the design does.
module tb_tx_arbiter;

  logic       clock = 1'b0;
  logic       reset;
  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       rx_err;
  logic       loc_req;
  logic [7:0] loc_byte;
  logic       loc_ack;
  logic [7:0] tx_byte;
  logic       tx_send;
  logic       tx_available;
  logic       busy;
  logic [7:0] ovr_cnt;
  logic [7:0] err_cnt;

  int vectors     = 0;
  int miscompares = 0;

  tx_arbiter dut (
    .clock       (clock),
    .reset       (reset),
    .rx_valid    (rx_valid),
    .rx_byte     (rx_byte),
    .rx_err      (rx_err),
    .loc_req     (loc_req),
    .loc_byte    (loc_byte),
    .loc_ack     (loc_ack),
    .tx_byte     (tx_byte),
    .tx_send     (tx_send),
    .tx_available(tx_available),
    .busy        (busy),
    .ovr_cnt     (ovr_cnt),
    .err_cnt     (err_cnt)
  );

  // Free-running clock
  always #5 clock = ~clock;

  // Hard stop in case something wedges the run
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic doReset;
    reset        = 1'b1;
    rx_valid     = 1'b0;
    rx_err       = 1'b0;
    rx_byte      = 8'h00;
    loc_req      = 1'b0;
    loc_byte     = 8'h00;
    tx_available = 1'b1;
    tick;
    tick;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset        = 1'b1;
    rx_valid     = 1'b1;
    rx_byte      = 8'h5C;
    rx_err       = 1'b0;
    loc_req      = 1'b0;
    loc_byte     = 8'h00;
    tx_available = 1'b1;
    tick;
    tick;
    vectors++;
    if ({tx_send, loc_ack, busy, tx_byte, ovr_cnt, err_cnt} !== 27'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got %h want %h",
               {tx_send, loc_ack, busy, tx_byte, ovr_cnt, err_cnt}, 27'd0);
    end
    reset    = 1'b0;
    rx_valid = 1'b0;
    tick;
    tick;
    vectors++;
    if ({tx_send, busy} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL reset_rx_discarded: got %b want %b", {tx_send, busy}, 2'b00);
    end
  endtask

  task automatic test_echo_basic;
    doReset;
    rx_valid = 1'b1;
    rx_byte  = 8'hA5;
    tick;
    rx_valid = 1'b0;
    vectors++;
    if ({tx_send, busy} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL echo_cycle1: got %b want %b", {tx_send, busy}, 2'b00);
    end
    tick;
    vectors++;
    if ({tx_send, loc_ack, busy, tx_byte} !== {1'b1, 1'b0, 1'b1, 8'hA5}) begin
      miscompares++;
      $display("[TB] FAIL echo_launch: got %h want %h",
               {tx_send, loc_ack, busy, tx_byte}, {1'b1, 1'b0, 1'b1, 8'hA5});
    end
    tick;
    vectors++;
    if ({tx_send, busy} !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL echo_send_one_cycle: got %b want %b", {tx_send, busy}, 2'b01);
    end
    tx_available = 1'b0;
    tick;
    tick;
    tick;
    vectors++;
    if ({tx_send, busy, tx_byte} !== {1'b0, 1'b1, 8'hA5}) begin
      miscompares++;
      $display("[TB] FAIL echo_wait_done: got %h want %h",
               {tx_send, busy, tx_byte}, {1'b0, 1'b1, 8'hA5});
    end
    tx_available = 1'b1;
    tick;
    vectors++;
    if ({tx_send, busy, tx_byte} !== {1'b0, 1'b0, 8'hA5}) begin
      miscompares++;
      $display("[TB] FAIL echo_done: got %h want %h",
               {tx_send, busy, tx_byte}, {1'b0, 1'b0, 8'hA5});
    end
  endtask

  task automatic test_tie;
    doReset;
    tx_available = 1'b0;
    rx_valid     = 1'b1;
    rx_byte      = 8'h11;
    loc_req      = 1'b1;
    loc_byte     = 8'h22;
    tick;
    rx_valid = 1'b0;
    tick;
    vectors++;
    if ({tx_send, busy} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL tie_no_grant_unavailable: got %b want %b", {tx_send, busy}, 2'b00);
    end
    tx_available = 1'b1;
    tick;
    vectors++;
    if ({tx_send, loc_ack, tx_byte} !== {1'b1, 1'b0, 8'h11}) begin
      miscompares++;
      $display("[TB] FAIL tie_echo_first: got %h want %h",
               {tx_send, loc_ack, tx_byte}, {1'b1, 1'b0, 8'h11});
    end
    tx_available = 1'b0;
    tick;
    tick;
    tx_available = 1'b1;
    tick;
    vectors++;
    if ({tx_send, busy} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL tie_first_done: got %b want %b", {tx_send, busy}, 2'b00);
    end
    tick;
    vectors++;
    if ({tx_send, loc_ack, tx_byte} !== {1'b1, 1'b1, 8'h22}) begin
      miscompares++;
      $display("[TB] FAIL tie_local_second: got %h want %h",
               {tx_send, loc_ack, tx_byte}, {1'b1, 1'b1, 8'h22});
    end
    loc_req      = 1'b0;
    tx_available = 1'b0;
    tick;
    vectors++;
    if ({tx_send, loc_ack, tx_byte} !== {1'b0, 1'b0, 8'h22}) begin
      miscompares++;
      $display("[TB] FAIL tie_ack_one_cycle: got %h want %h",
               {tx_send, loc_ack, tx_byte}, {1'b0, 1'b0, 8'h22});
    end
    tick;
    tx_available = 1'b1;
    tick;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL tie_second_done: got %b want %b", busy, 1'b0);
    end
  endtask

  task automatic test_overrun;
    doReset;
    tx_available = 1'b0;
    for (int v = 1; v <= 3; v++) begin
      rx_valid = 1'b1;
      rx_byte  = 8'(v);
      tick;
    end
    rx_valid = 1'b0;
    vectors++;
    if ({tx_send, ovr_cnt} !== {1'b0, 8'd2}) begin
      miscompares++;
      $display("[TB] FAIL overrun_count: got %h want %h", {tx_send, ovr_cnt}, {1'b0, 8'd2});
    end
    tx_available = 1'b1;
    tick;
    vectors++;
    if ({tx_send, tx_byte} !== {1'b1, 8'h03}) begin
      miscompares++;
      $display("[TB] FAIL overrun_last_byte: got %h want %h", {tx_send, tx_byte}, {1'b1, 8'h03});
    end
    tx_available = 1'b0;
    tick;
    tick;
    tx_available = 1'b1;
    tick;
    tick;
    tick;
    vectors++;
    if ({tx_send, busy, ovr_cnt} !== {1'b0, 1'b0, 8'd2}) begin
      miscompares++;
      $display("[TB] FAIL overrun_single_send: got %h want %h",
               {tx_send, busy, ovr_cnt}, {1'b0, 1'b0, 8'd2});
    end
  endtask

  task automatic test_timeout;
    doReset;
    rx_valid = 1'b1;
    rx_byte  = 8'h5A;
    tick;
    rx_valid = 1'b0;
    tick;
    vectors++;
    if ({tx_send, tx_byte} !== {1'b1, 8'h5A}) begin
      miscompares++;
      $display("[TB] FAIL timeout_launch: got %h want %h", {tx_send, tx_byte}, {1'b1, 8'h5A});
    end
    loc_req  = 1'b1;
    loc_byte = 8'h77;
    tick;
    for (int k = 1; k <= 7; k++) begin
      tick;
      vectors++;
      if ({tx_send, busy} !== 2'b01) begin
        miscompares++;
        $display("[TB] FAIL timeout_still_waiting_%0d: got %b want %b", k, {tx_send, busy}, 2'b01);
      end
    end
    tick;
    vectors++;
    if ({tx_send, busy} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL timeout_back_idle: got %b want %b", {tx_send, busy}, 2'b00);
    end
    tick;
    vectors++;
    if ({tx_send, loc_ack, tx_byte} !== {1'b1, 1'b1, 8'h77}) begin
      miscompares++;
      $display("[TB] FAIL timeout_next_served: got %h want %h",
               {tx_send, loc_ack, tx_byte}, {1'b1, 1'b1, 8'h77});
    end
    loc_req      = 1'b0;
    tx_available = 1'b0;
    tick;
    tick;
    tx_available = 1'b1;
    tick;
  endtask

  task automatic test_err;
    doReset;
    rx_valid = 1'b1;
    rx_err   = 1'b1;
    rx_byte  = 8'hFF;
    tick;
    rx_valid = 1'b0;
    rx_err   = 1'b0;
    tick;
`ifdef ECHO_ERR_DROP_EN
    vectors++;
    if ({tx_send, busy, err_cnt} !== {1'b0, 1'b0, 8'd1}) begin
      miscompares++;
      $display("[TB] FAIL err_dropped: got %h want %h", {tx_send, busy, err_cnt}, {1'b0, 1'b0, 8'd1});
    end
    tick;
    vectors++;
    if ({tx_send, busy} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL err_never_sent: got %b want %b", {tx_send, busy}, 2'b00);
    end
`else
    vectors++;
    if ({tx_send, tx_byte, err_cnt} !== {1'b1, 8'hFF, 8'd0}) begin
      miscompares++;
      $display("[TB] FAIL err_echoed: got %h want %h", {tx_send, tx_byte, err_cnt}, {1'b1, 8'hFF, 8'd0});
    end
    tx_available = 1'b0;
    tick;
    tick;
    tx_available = 1'b1;
    tick;
    vectors++;
    if ({busy, err_cnt} !== {1'b0, 8'd0}) begin
      miscompares++;
      $display("[TB] FAIL err_count_zero: got %h want %h", {busy, err_cnt}, {1'b0, 8'd0});
    end
`endif
  endtask

  task automatic test_reset_mid;
    doReset;
    tx_available = 1'b0;
    rx_valid     = 1'b1;
    rx_byte      = 8'h01;
    tick;
    rx_byte = 8'h02;
    tick;
    rx_valid     = 1'b0;
    loc_req      = 1'b1;
    loc_byte     = 8'h33;
    tx_available = 1'b1;
    tick;
    vectors++;
    if ({tx_send, tx_byte, ovr_cnt} !== {1'b1, 8'h02, 8'd1}) begin
      miscompares++;
      $display("[TB] FAIL midreset_setup: got %h want %h", {tx_send, tx_byte, ovr_cnt}, {1'b1, 8'h02, 8'd1});
    end
    tx_available = 1'b0;
    tick;
    tick;
    vectors++;
    if ({tx_send, busy} !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL midreset_wait_done: got %b want %b", {tx_send, busy}, 2'b01);
    end
    reset    = 1'b1;
    rx_valid = 1'b1;
    rx_byte  = 8'h44;
    tick;
    reset    = 1'b0;
    rx_valid = 1'b0;
    loc_req  = 1'b0;
    vectors++;
    if ({tx_send, loc_ack, busy, tx_byte, ovr_cnt, err_cnt} !== 27'd0) begin
      miscompares++;
      $display("[TB] FAIL midreset_outputs: got %h want %h",
               {tx_send, loc_ack, busy, tx_byte, ovr_cnt, err_cnt}, 27'd0);
    end
    tx_available = 1'b1;
    tick;
    tick;
    vectors++;
    if ({tx_send, loc_ack, busy} !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL midreset_nothing_pending: got %b want %b", {tx_send, loc_ack, busy}, 3'b000);
    end
  endtask

  task automatic test_random;
    bit       mPend;
    bit       mIdle;
    bit       mLaunch;
    bit       mSawLow;
    bit       mLastLocal;
    bit       mSend;
    bit       mAck;
    bit       gE;
    bit       gL;
    bit       drop;
    bit [7:0] mEcho;
    bit [7:0] mTx;
    bit [7:0] mOvr;
    bit [7:0] mErr;
    int       mQuiet;
    doReset;
    mPend = 0; mIdle = 1; mLaunch = 0; mSawLow = 0; mLastLocal = 1;
    mSend = 0; mAck = 0; mEcho = 0; mTx = 0; mOvr = 0; mErr = 0; mQuiet = 0;
    for (int i = 0; i < 3000; i++) begin
      reset        = ($urandom_range(0, 199) == 0);
      rx_valid     = ($urandom_range(0, 3) == 0);
      rx_byte      = 8'($urandom);
      rx_err       = ($urandom_range(0, 4) == 0);
      tx_available = ($urandom_range(0, 2) != 0);
      if (!loc_req && $urandom_range(0, 3) == 0) begin
        loc_req  = 1'b1;
        loc_byte = 8'($urandom);
      end
      if (reset) begin
        mPend = 0; mIdle = 1; mLaunch = 0; mSawLow = 0; mLastLocal = 1;
        mSend = 0; mAck = 0; mEcho = 0; mTx = 0; mOvr = 0; mErr = 0; mQuiet = 0;
      end else begin
        gE = 0;
        gL = 0;
        if (mIdle && tx_available) begin
          if (mPend && loc_req) begin
            gE = mLastLocal;
            gL = !mLastLocal;
          end else begin
            gE = mPend;
            gL = !mPend && loc_req;
          end
        end
        mSend = gE | gL;
        mAck  = gL;
        if (gE) mTx = mEcho;
        if (gL) mTx = loc_byte;
        if (gE | gL) mLastLocal = gL;
        if (gE | gL) begin
          mIdle   = 0;
          mLaunch = 1;
        end else if (mLaunch) begin
          mLaunch = 0;
          mSawLow = 0;
          mQuiet  = 0;
        end else if (!mIdle) begin
          if (mSawLow) begin
            if (tx_available) mIdle = 1;
          end else if (!tx_available) begin
            mSawLow = 1;
          end else begin
            mQuiet++;
            if (mQuiet == 8) mIdle = 1;
          end
        end
        drop = 0;
`ifdef ECHO_ERR_DROP_EN
        drop = rx_err;
`endif
        if (rx_valid && drop) begin
          if (mErr != 8'hFF) mErr++;
          if (gE) mPend = 0;
        end else if (rx_valid) begin
          if (mPend && !gE && mOvr != 8'hFF) mOvr++;
          mEcho = rx_byte;
          mPend = 1;
        end else if (gE) begin
          mPend = 0;
        end
      end
      tick;
      vectors++;
      if ({tx_send, loc_ack, busy, tx_byte, ovr_cnt, err_cnt} !==
          {mSend, mAck, !mIdle, mTx, mOvr, mErr}) begin
        miscompares++;
        $display("[TB] FAIL random_cycle_%0d: got %h want %h", i,
                 {tx_send, loc_ack, busy, tx_byte, ovr_cnt, err_cnt},
                 {mSend, mAck, !mIdle, mTx, mOvr, mErr});
      end
      if (loc_ack) loc_req = 1'b0;
    end
    reset    = 1'b0;
    rx_valid = 1'b0;
    loc_req  = 1'b0;
  endtask

  // Run every scenario in order, then report
  initial begin
    test_reset;
    test_echo_basic;
    test_tie;
    test_overrun;
    test_timeout;
    test_err;
    test_reset_mid;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tx_arbiter.md
TX_ARBITER -- requirements
Module: tx_arbiter

Interface
REQ-001 SHALL have port clock, input, 1, single system clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have port rx_valid, input, 1, one-cycle pulse: received byte ready (echo requester).
REQ-004 SHALL have port rx_byte, input, 8, received byte; sampled when rx_valid=1.
REQ-005 SHALL have port rx_err, input, 1, frame or parity error flag for rx_byte; sampled with rx_valid.
REQ-006 SHALL have port loc_req, input, 1, local requester level request.
REQ-007 SHALL have port loc_byte, input, 8, local byte; stable while loc_req=1.
REQ-008 SHALL have port loc_ack, output, 1, one-cycle pulse: loc_byte accepted.
REQ-009 SHALL have port tx_byte, output, 8, byte to transmitter.
REQ-010 SHALL have port tx_send, output, 1, one-cycle start pulse to transmitter.
REQ-011 SHALL have port tx_available, input, 1, transmitter idle (1) / shifting (0).
REQ-012 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-013 SHALL have port ovr_cnt, output, 8, echo overrun count, saturating at 255.
REQ-014 SHALL have port err_cnt, output, 8, dropped errored echo bytes, saturating at 255.

Function
REQ-015 SHALL hold echo bytes in a one-entry register with a pending flag; rx_valid loads it and sets pending.
REQ-016 SHALL, on rx_valid while pending and not being granted that cycle, overwrite the byte and increment ovr_cnt.
REQ-017 SHALL, on rx_valid in the same cycle the echo entry is granted, load the new byte, keep pending=1, and not count an overrun.
REQ-018 SHALL implement states IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
REQ-019 SHALL, in IDLE with tx_available=1 and at least one request (echo pending or loc_req), grant one requester, register its byte into tx_byte, and move to LAUNCH next cycle.
REQ-020 SHALL stay in IDLE while tx_available=0, with no grant.
REQ-021 SHALL arbitrate round-robin: if both request, grant the requester not granted last; a single requester is always granted.
REQ-022 SHALL clear echo pending at grant (subject to REQ-017); local grant pulses loc_ack during the LAUNCH cycle.
REQ-023 SHALL assert tx_send=1 for exactly the LAUNCH cycle, then go to WAIT_BUSY.
REQ-024 SHALL leave WAIT_BUSY for WAIT_DONE when tx_available=0; if tx_available stays 1 for 8 consecutive WAIT_BUSY cycles, return to IDLE.
REQ-025 SHALL leave WAIT_DONE for IDLE when tx_available=1.
REQ-026 SHALL keep tx_byte stable from LAUNCH until the next grant.
REQ-027 SHALL give grant-to-tx_send latency of 1 cycle, and rx_valid-to-tx_send minimum latency of 2 cycles when idle.

Reset
REQ-028 SHALL, on reset, force state IDLE, tx_send=0, loc_ack=0, busy=0, tx_byte=8'h00, echo pending=0, ovr_cnt=0, err_cnt=0, timeout counter=0.
REQ-029 SHALL reset last-grant to local, so echo wins the first tie.
REQ-030 SHALL, on reset mid-operation, abandon the transfer without asserting loc_ack; rx_valid coincident with reset is discarded.

Configuration
REQ-031 SHALL, with ECHO_ERR_DROP_EN defined, not load rx_valid bytes with rx_err=1 and increment err_cnt instead.
REQ-032 SHALL, without ECHO_ERR_DROP_EN, treat errored bytes as normal echo bytes, and tie err_cnt to 0.

Verification
REQ-033 SHALL cover: rx_valid with 8'hA5, tx_available=1 -> tx_send pulse 2 cycles later with tx_byte=8'hA5; busy until tx_available returns 1.
REQ-034 SHALL cover: echo pending 8'h11 and loc_req with 8'h22 simultaneously after reset -> 8'h11 sent first, then 8'h22 with loc_ack pulse.
REQ-035 SHALL cover: three rx_valid pulses (01,02,03) while tx_available=0 -> only 8'h03 sent, ovr_cnt=2.
REQ-036 SHALL cover: tx_available held 1 after tx_send -> return to IDLE after 8 WAIT_BUSY cycles; next request is served.
REQ-037 SHALL cover: ECHO_ERR_DROP_EN defined, rx_valid with rx_err=1, byte 8'hFF -> no tx_send, err_cnt=1; undefined -> 8'hFF sent, err_cnt=0.
REQ-038 SHALL cover: reset asserted in WAIT_DONE -> next cycle IDLE, all outputs at reset values, ovr_cnt=0.
